// File: rtl/hdmi_text_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hdmi_text_pkg : response codes, FSM states and address decode for the
//                 HDMI text VRAM AXI slave.                      Rev 1.0
// ----------------------------------------------------------------------------
package hdmi_text_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RAM  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    REG_VRAM = 2'd0,
    REG_PAL  = 2'd1,
    REG_CTRL = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  function automatic region_t decode_region(input logic [31:0] widx,
                                            input int unsigned vram_words,
                                            input int unsigned pal_entries);
    if (widx < vram_words)                    return REG_VRAM;
    if (widx < vram_words + pal_entries)      return REG_PAL;
    if (widx == vram_words + pal_entries)     return REG_CTRL;
    return REG_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_text_vram_dp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hdmi_text_vram_dp : 32-bit byte-enable dual-port VRAM, port A read/write,
//                     port B read-only, both read-first and registered. Rev 1.0
// ----------------------------------------------------------------------------
module hdmi_text_vram_dp #(
  parameter int WORDS = 1200,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_en_i,
  input  logic [3:0]    a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [31:0]   a_wdata_i,
  output logic [31:0]   a_rdata_o,
  input  logic [AW-1:0] b_addr_i,
  output logic [31:0]   b_rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;

  always_ff @(posedge clk_i) begin
    if (a_en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (a_we_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
    end
  end

  // Port A output only reloads on pure reads so a pending AXI read result
  // survives later write commits while the master stalls rready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i && (a_we_i == 4'b0000)) a_rdata_q <= mem_q[a_addr_i];
      b_rdata_q <= (32'(b_addr_i) < WORDS) ? mem_q[b_addr_i] : '0;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/hdmi_text_axi_vram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hdmi_text_axi_vram : AXI4-Lite slave owning text VRAM, palette bank and
//                      control register, with a video read port.  Rev 1.0
// ----------------------------------------------------------------------------
module hdmi_text_axi_vram
  import hdmi_text_pkg::*;
#(
  parameter int          C_AXI_DATA_WIDTH = 32,
  parameter int          C_AXI_ADDR_WIDTH = 16,
  parameter int          VRAM_WORDS       = 1200,
  parameter int          PAL_ENTRIES      = 8,
  parameter logic [31:0] CTRL_RESET       = 32'h0000_0000
) (
  input  logic                            axi_aclk,
  input  logic                            axi_areset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic                            axi_awvalid,
  output logic                            axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                            axi_wvalid,
  output logic                            axi_wready,
  output logic [1:0]                      axi_bresp,
  output logic                            axi_bvalid,
  input  logic                            axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_araddr,
  input  logic                            axi_arvalid,
  output logic                            axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                      axi_rresp,
  output logic                            axi_rvalid,
  input  logic                            axi_rready,
  input  logic [$clog2(VRAM_WORDS)-1:0]   vid_addr,
  output logic [31:0]                     vid_data,
  output logic [32*PAL_ENTRIES-1:0]       pal_flat,
  output logic [31:0]                     ctrl_reg
);

  localparam int VAW = $clog2(VRAM_WORDS);
  localparam int IW  = C_AXI_ADDR_WIDTH - 2;

  wr_state_t   wr_state_q;
  rd_state_t   rd_state_q;
  logic        aw_full_q, w_full_q;
  logic [IW-1:0] aw_idx_q, ar_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q, rvalid_q, rd_vram_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] reg_rdata_q, reg_rdata_d;
  logic [31:0] pal_q [PAL_ENTRIES];
  logic [31:0] ctrl_q;

  logic [31:0] wr_idx, rd_idx;
  region_t     wr_region, rd_region;
  logic        commit;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [VAW-1:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{axi_awaddr[1:0], axi_araddr[1:0]};

  assign wr_idx    = 32'(aw_idx_q);
  assign rd_idx    = 32'(ar_idx_q);
  assign wr_region = decode_region(wr_idx, VRAM_WORDS, PAL_ENTRIES);
  assign rd_region = decode_region(rd_idx, VRAM_WORDS, PAL_ENTRIES);
  assign commit    = (wr_state_q == W_IDLE) && aw_full_q && w_full_q;

  // Single AXI-side RAM port: a write commit owns it, a colliding R_RAM waits.
  assign ram_en   = commit ? (wr_region == REG_VRAM)
                           : ((rd_state_q == R_RAM) && (rd_region == REG_VRAM));
  assign ram_we   = (commit && (wr_region == REG_VRAM)) ? wstrb_q : 4'b0000;
  assign ram_addr = commit ? aw_idx_q[VAW-1:0] : ar_idx_q[VAW-1:0];

  hdmi_text_vram_dp #(
    .WORDS (VRAM_WORDS),
    .AW    (VAW)
  ) u_vram (
    .clk_i     (axi_aclk),
    .rst_i     (axi_areset),
    .a_en_i    (ram_en),
    .a_we_i    (ram_we),
    .a_addr_i  (ram_addr),
    .a_wdata_i (wdata_q),
    .a_rdata_o (ram_rdata),
    .b_addr_i  (vid_addr),
    .b_rdata_o (vid_data)
  );

  assign axi_awready = !axi_areset && (wr_state_q == W_IDLE) && !aw_full_q;
  assign axi_wready  = !axi_areset && (wr_state_q == W_IDLE) && !w_full_q;
  assign axi_arready = !axi_areset && (rd_state_q == R_IDLE);
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rresp   = rresp_q;
  assign axi_rdata   = rvalid_q ? (rd_vram_q ? ram_rdata : reg_rdata_q) : '0;
  assign ctrl_reg    = ctrl_q;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_state_q <= W_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      ctrl_q     <= CTRL_RESET;
      for (int k = 0; k < PAL_ENTRIES; k++) pal_q[k] <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (axi_awvalid && axi_awready) begin
            aw_full_q <= 1'b1;
            aw_idx_q  <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
          end
          if (axi_wvalid && axi_wready) begin
            w_full_q <= 1'b1;
            wdata_q  <= axi_wdata;
            wstrb_q  <= axi_wstrb;
          end
          if (commit) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb_q[b] && (wr_region == REG_CTRL))
                ctrl_q[8*b +: 8] <= wdata_q[8*b +: 8];
              for (int k = 0; k < PAL_ENTRIES; k++) begin
                if (wstrb_q[b] && (wr_region == REG_PAL) && (wr_idx == 32'(VRAM_WORDS + k)))
                  pal_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
              end
            end
            bvalid_q   <= 1'b1;
            bresp_q    <= (wr_region == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_rdata_d = '0;
    if (rd_region == REG_CTRL) reg_rdata_d = ctrl_q;
    for (int k = 0; k < PAL_ENTRIES; k++) begin
      if ((rd_region == REG_PAL) && (rd_idx == 32'(VRAM_WORDS + k))) reg_rdata_d = pal_q[k];
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rd_state_q  <= R_IDLE;
      ar_idx_q    <= '0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rd_vram_q   <= 1'b0;
      reg_rdata_q <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (axi_arvalid) begin
            ar_idx_q   <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
            rd_state_q <= R_RAM;
          end
        end
        R_RAM: begin
          if (!commit) begin
            reg_rdata_q <= reg_rdata_d;
            rd_vram_q   <= (rd_region == REG_VRAM);
            rresp_q     <= (rd_region == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            rvalid_q    <= 1'b1;
            rd_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < PAL_ENTRIES; k++) begin : g_pal
    assign pal_flat[32*k +: 32] = pal_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_text_axi_vram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hdmi_text_axi_vram : directed self-checking bench for hdmi_text_axi_vram.
//                                                                 Rev 1.0
// ----------------------------------------------------------------------------
module tb_hdmi_text_axi_vram;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata, rdata, vid_data, ctrl_reg;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [10:0]  vid_addr;
  logic [255:0] pal_flat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hdmi_text_axi_vram dut (
    .axi_aclk    (clk),
    .axi_areset  (rst),
    .axi_awaddr  (awaddr),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wstrb   (wstrb),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_bresp   (bresp),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .axi_araddr  (araddr),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_rdata   (rdata),
    .axi_rresp   (rresp),
    .axi_rvalid  (rvalid),
    .axi_rready  (rready),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .pal_flat    (pal_flat),
    .ctrl_reg    (ctrl_reg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold, output logic [1:0] resp);
    int  n;
    bit  hs_aw, hs_w, stable;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      n++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("wr_timeout", n, 0);
    resp   = bresp;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bvalid || bresp !== resp || awready || wready) stable = 1'b0;
    end
    if (hold > 0) check_eq("b_backpressure_stable", 32'(stable), 1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    bit stable;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      if (arready) begin
        @(negedge clk);
        arvalid = 1'b0;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    lat = 1;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      lat++;
      n++;
    end
    if (n >= 50) check_eq("rd_timeout", n, 0);
    data   = rdata;
    resp   = rresp;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rvalid || rdata !== data || rresp !== resp || arready) stable = 1'b0;
    end
    if (hold > 0) check_eq("r_backpressure_stable", 32'(stable), 1);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;

    rst = 1'b1;
    awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0; vid_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_handshakes", {27'b0, awready, wready, arready, bvalid, rvalid}, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_resps", {28'b0, bresp, rresp}, 0);
    check_eq("rst_vid_data", vid_data, 0);
    check_eq("rst_ctrl", ctrl_reg, 32'h0000_0000);
    check_eq("rst_pal_any", 32'(|pal_flat), 0);
    rst = 1'b0;
    @(negedge clk);

    // AW leads W by three cycles
    awaddr = 16'h0010; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check_eq("aw_latched_blocks_awready", 32'(awready), 0);
    repeat (2) @(negedge clk);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("split_bvalid", 32'(bvalid), 1);
    check_eq("split_bresp", 32'(bresp), 0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("split_single_response", 32'(bvalid), 0);
    axi_read(16'h0010, 0, data, resp, lat);
    check_eq("split_readback", data, 32'hDEAD_BEEF);
    check_eq("read_latency", 32'(lat), 2);

    // byte strobes, including an all-zero strobe
    axi_write(16'h0014, 32'h1122_3344, 4'hF, 0, resp);
    axi_write(16'h0014, 32'hAABB_CCDD, 4'b0101, 0, resp);
    axi_read(16'h0014, 0, data, resp, lat);
    check_eq("strobe_merge", data, 32'h11BB_33DD);
    axi_write(16'h0014, 32'hFFFF_FFFF, 4'b0000, 0, resp);
    check_eq("strobe_zero_bresp", 32'(resp), 0);
    axi_read(16'h0014, 0, data, resp, lat);
    check_eq("strobe_zero_unchanged", data, 32'h11BB_33DD);

    // map edges
    axi_write(16'h12BC, 32'h0000_0007, 4'hF, 0, resp);
    check_eq("last_vram_bresp", 32'(resp), 0);
    axi_read(16'h12BC, 0, data, resp, lat);
    check_eq("last_vram_read", data, 32'h0000_0007);
    axi_write(16'h12C0, 32'h00F0_F0F0, 4'hF, 0, resp);
    check_eq("pal0_flat", pal_flat[31:0], 32'h00F0_F0F0);
    axi_read(16'h12C0, 0, data, resp, lat);
    check_eq("pal0_read", data, 32'h00F0_F0F0);
    axi_write(16'h12DC, 32'h0012_3456, 4'hF, 0, resp);
    check_eq("pal7_flat", pal_flat[255:224], 32'h0012_3456);
    axi_write(16'h12E0, 32'h001F_6000, 4'hF, 0, resp);
    check_eq("ctrl_reg", ctrl_reg, 32'h001F_6000);
    axi_read(16'h12E0, 0, data, resp, lat);
    check_eq("ctrl_read", data, 32'h001F_6000);
    axi_write(16'h12E4, 32'hFFFF_FFFF, 4'hF, 0, resp);
    check_eq("unmapped_bresp", 32'(resp), 32'h2);
    check_eq("unmapped_no_ctrl_change", ctrl_reg, 32'h001F_6000);
    axi_read(16'h12E4, 0, data, resp, lat);
    check_eq("unmapped_rdata", data, 0);
    check_eq("unmapped_rresp", 32'(resp), 32'h2);

    vid_addr = 11'd1199;
    repeat (2) @(negedge clk);
    check_eq("vid_last_word", vid_data, 32'h0000_0007);
    vid_addr = 11'd1200;
    repeat (2) @(negedge clk);
    check_eq("vid_out_of_range", vid_data, 0);

    // backpressure on B and R
    axi_write(16'h0004, 32'h0BAD_CAFE, 4'hF, 10, resp);
    check_eq("bp_bresp", 32'(resp), 0);
    axi_read(16'h0004, 10, data, resp, lat);
    check_eq("bp_rdata", data, 32'h0BAD_CAFE);

    // write commit collides with R_RAM on word 7
    axi_write(16'h001C, 32'h1234_5678, 4'hF, 0, resp);
    vid_addr = 11'd7;
    @(negedge clk);
    check_eq("coll_all_ready", {29'b0, awready, wready, arready}, 32'h7);
    awaddr = 16'h001C; wdata = 32'h0000_0055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 16'h001C; arvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check_eq("coll_vid_old", vid_data, 32'h1234_5678);
    check_eq("coll_rvalid_delayed", 32'(rvalid), 0);
    @(negedge clk);
    check_eq("coll_rvalid_late", 32'(rvalid), 1);
    check_eq("coll_rdata_new", rdata, 32'h0000_0055);
    check_eq("coll_vid_new", vid_data, 32'h0000_0055);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    @(negedge clk);

    // reset during a half-finished write
    axi_write(16'h0050, 32'hA5A5_A5A5, 4'hF, 0, resp);
    @(negedge clk);
    awaddr = 16'h0050; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_handshakes", {27'b0, awready, wready, arready, bvalid, rvalid}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_ctrl_reset", ctrl_reg, 32'h0000_0000);
    check_eq("midrst_pal_reset", pal_flat[31:0], 0);
    axi_read(16'h0050, 0, data, resp, lat);
    check_eq("midrst_no_commit", data, 32'hA5A5_A5A5);
    axi_write(16'h0050, 32'h600D_D00D, 4'hF, 0, resp);
    check_eq("midrst_new_write_bresp", 32'(resp), 0);
    axi_read(16'h0050, 0, data, resp, lat);
    check_eq("midrst_new_write_data", data, 32'h600D_D00D);
    axi_read(16'h0010, 0, data, resp, lat);
    check_eq("midrst_vram_retained", data, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_text_axi_vram.md
Name: hdmi_text_axi_vram

Overview:
- Parametrised AXI4-Lite slave that owns the text-mode character VRAM, colour palette registers and control register of the HDMI text controller.
- Generalises the fixed 600-word/1-control-register map to configurable VRAM depth, a palette bank and per-byte write strobes.
- A second synchronous read port feeds the character/pixel draw pipeline.
- Sits between the AXI interconnect and the text renderer inside the controller top level.

Parameters:
- C_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 16, AXI byte address width.
- VRAM_WORDS, 1200, number of 32-bit VRAM words (80x30 chars, 2 chars/word).
- PAL_ENTRIES, 8, number of 32-bit palette registers.
- CTRL_RESET, 32'h0000_0000, reset value of the control register.

Ports:
- axi_aclk  in  1  sole clock, shared by AXI and video side.
- axi_areset  in  1  synchronous, active-high reset.
- axi_awaddr  in  C_AXI_ADDR_WIDTH  write byte address.
- axi_awvalid/axi_awready  in/out  1  AW handshake.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte strobes.
- axi_wvalid/axi_wready  in/out  1  W handshake.
- axi_bresp  out  2  write response (00 OKAY, 10 SLVERR).
- axi_bvalid/axi_bready  out/in  1  B handshake.
- axi_araddr  in  C_AXI_ADDR_WIDTH  read byte address.
- axi_arvalid/axi_arready  in/out  1  AR handshake.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rvalid/axi_rready  out/in  1  R handshake.
- vid_addr  in  $clog2(VRAM_WORDS)  VRAM word index requested by renderer.
- vid_data  out  32  VRAM word at vid_addr, registered.
- pal_flat  out  32*PAL_ENTRIES  palette registers, entry k at [32k+31:32k].
- ctrl_reg  out  32  control register.

Behaviour:
- Address map, by word index = addr[C_AXI_ADDR_WIDTH-1:2]:
  - 0..VRAM_WORDS-1: VRAM.
  - VRAM_WORDS..VRAM_WORDS+PAL_ENTRIES-1: palette.
  - VRAM_WORDS+PAL_ENTRIES: ctrl.
  - Anything above: unmapped.
  - addr[1:0] is ignored.
- Reset: all ready/valid outputs 0; bresp/rresp 00; rdata 0; vid_data 0; ctrl = CTRL_RESET; palette all 0; AW/W holding latches cleared. VRAM contents are not cleared.
- Reset asserted mid-transaction aborts it: no write commit, no response. The master must restart the transaction after reset.
- Write channel, states W_IDLE and W_RESP:
  - awready = 1 in W_IDLE while no address is latched. wready = 1 in W_IDLE while no data is latched.
  - AW and W are accepted independently, in either order or in the same cycle.
  - The commit cycle is the first cycle with both address and data latched. In that cycle, each byte with wstrb[i]=1 is written and the FSM moves to W_RESP.
  - W_RESP: bvalid = 1. bresp = 10 if the address is unmapped (no state changes), else 00.
  - On bvalid & bready, go to W_IDLE and clear both latches.
  - wstrb = 0 is legal: nothing is written, bresp = 00.
- Read channel, states R_IDLE, R_RAM, R_DATA:
  - arready = 1 only in R_IDLE. An AR handshake latches the address and moves to R_RAM.
  - R_RAM issues the VRAM read, or a register mux read, and moves to R_DATA next cycle.
  - R_DATA: rvalid = 1 and rdata/rresp are held stable until rready, then return to R_IDLE.
  - Nominal latency: rvalid rises 2 cycles after the AR handshake edge.
  - Unmapped read: rdata 0, rresp 10.
- Collision: the AXI VRAM port is single-access per cycle. If a write commit and R_RAM occur in the same cycle, the write wins and R_RAM repeats the next cycle. rvalid is then delayed by 1 cycle and returns the newly written data.
- Video port is independent: vid_data = VRAM[vid_addr] one cycle after vid_addr is presented.
  - Same-cycle AXI write to the same word: vid_data shows old data (read-first).
  - vid_addr >= VRAM_WORDS returns 0.
- ctrl_reg and pal_flat update the cycle after the commit.

Decomposition:
- Package hdmi_text_pkg: AXI response constants (RESP_OKAY, RESP_SLVERR), write and read FSM state enums, and address-decode function returning region {VRAM, PAL, CTRL, NONE}.
- Sub-module hdmi_text_vram_dp: true dual-port byte-enable RAM, 32-bit, VRAM_WORDS deep. Port A is AXI read/write; port B is video read-only. Both ports are read-first and registered.

Test Plan:
- AW presented 3 cycles before W, addr 0x0010, data 0xDEADBEEF, strb F -> single commit, bvalid with bresp 00; read 0x0010 returns 0xDEADBEEF with rvalid 2 cycles after AR handshake.
- Byte strobes: write 0x11223344 strb F to word 5, then 0xAABBCCDD strb 0101 -> readback 0x11BB33DD.
- Map edges, VRAM_WORDS=1200:
  - write word 1199 = 7 -> OKAY.
  - palette word 1200 = 0x00F0F0F0 -> pal_flat[31:0] = 0x00F0F0F0.
  - ctrl word 1208 = 0x001F6000 -> ctrl_reg = 0x001F6000.
  - word 1209 -> bresp 10 and read returns 0/rresp 10.
- Backpressure: hold bready=0 for 10 cycles and rready=0 for 10 cycles -> bvalid/rvalid and rdata stay stable, awready/arready stay 0 until release.
- Collision: read of word 7 reaches R_RAM in the commit cycle of write 0x55 to word 7 -> rvalid one cycle late, rdata 0x55. Video port reading word 7 in that cycle gives the old value, then 0x55.
- Reset mid-write: AW accepted, W not yet sent, assert axi_areset 1 cycle -> all handshake outputs 0, no commit. Subsequent full write succeeds; previously written VRAM words are retained.
